tt_rebot449_alu_sequencer: RTL and testbench
============================================

TT_REBOT449_ALU_SEQUENCER -- requirements
Module: tt_rebot449_alu_sequencer

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst_n  input  1  reset, synchronous, active-low; sampled on rising clk edge.
REQ-003 in_data  input  8  command/operand byte.
REQ-004 in_valid  input  1  in_data valid this cycle.
REQ-005 in_ready  output  1  sequencer accepts in_data this cycle; transfer when in_valid & in_ready.
REQ-006 out_data  output  8  ALU result byte.
REQ-007 out_valid  output  1  out_data valid; held with out_data stable until accepted.
REQ-008 out_ready  input  1  consumer accepts; transfer when out_valid & out_ready.
REQ-009 flags  output  2  {carry, zero} from last executed op.
REQ-010 busy  output  1  high in any state other than IDLE.

Function
REQ-011 Command byte fields SHALL be: [7:6] cmd (00 LOAD_A, 01 LOAD_B, 10 EXEC, 11 NOP); [3] chain; [2:0] op.
REQ-012 Operand registers A, B SHALL be 8-bit, written only by the byte following LOAD_A / LOAD_B, or by chain writeback.
REQ-013 FSM states SHALL be IDLE, GET_A, GET_B, EXEC, OUT.
REQ-014 IDLE: accepted LOAD_A -> GET_A; LOAD_B -> GET_B; EXEC -> EXEC; NOP -> IDLE, no state change.
REQ-015 GET_A / GET_B: next accepted byte written to A / B -> IDLE.
REQ-016 in_ready SHALL be 1 in IDLE, GET_A, GET_B; 0 in EXEC, OUT.
REQ-017 EXEC (one cycle): register result, flags; chain=1 also writes result into A same edge; -> OUT.
REQ-018 OUT: out_valid=1; on out_ready -> IDLE with out_valid=0 next cycle.
REQ-019 Latency: EXEC byte accepted edge N; out_valid high from edge N+2; min command-to-command spacing 3 cycles.
REQ-020 op 000 A|B; 001 ~(A&B); 010 ~(A|B); 011 A&B; 100 A+B; 101 B-A; 110/111 result 0x00.
REQ-021 Arithmetic mod 256; carry = bit 8 of A+B for op 100; carry = borrow (A>B) for op 101; carry=0 all other ops.
REQ-022 zero = (result == 0x00), all ops including 110/111.
REQ-023 out_data, flags SHALL hold last result until next EXEC, including after OUT exits.
REQ-024 in_valid while in_ready=0 SHALL be ignored (byte not consumed, no side effect).
REQ-025 out_ready while out_valid=0 SHALL be ignored.
REQ-026 EXEC chain op reads A before writeback (no forwarding hazard; single edge).

Reset
REQ-027 rst_n=0 at a clk edge SHALL force: state IDLE, A=B=0x00, out_data=0x00, out_valid=0, flags=00, busy=0, in_ready=1 from next cycle.
REQ-028 Reset in any state (including GET_A mid-load, OUT with out_valid=1) SHALL abort the operation; pending result discarded.
REQ-029 rst_n deasserted: first command acceptable on the first edge with rst_n=1.

Verification
REQ-030 LOAD_A 0x00, 0xFF; LOAD_B 0x40, 0x01; EXEC 0x84 -> out_data 0x00, flags carry=1 zero=1.
REQ-031 A=0x07, B=0x05, EXEC 0x85 -> out_data 0xFE, carry=1, zero=0; A=0x05, B=0x07 -> 0x02, carry=0.
REQ-032 A=0x0F, B=0xF0, EXEC ops 000..111 in turn -> 0xFF, 0xFF, 0x00, 0x00, 0xFF, 0xE1, 0x00, 0x00.
REQ-033 A=0x01, B=0x01, EXEC 0x8C three times (chain add) -> outputs 0x02, 0x03, 0x04; A=0x04 at end.
REQ-034 Hold out_ready=0 10 cycles in OUT with in_valid=1 -> out_valid, out_data stable, in_ready=0, no byte consumed; then out_ready=1 -> IDLE next cycle.
REQ-035 rst_n=0 for one cycle while in GET_A and again while in OUT -> all outputs at REQ-027 values next cycle; the following LOAD_A accepted normally.

Source files
------------

// File: rtl/tt_rebot449_alu_sequencer.sv
// Byte-stream ALU sequencer: loads operands A/B, executes one of eight ops,
// and holds the result on a valid/ready output until the consumer takes it.
module tt_rebot449_alu_sequencer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [1:0] flags,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GET_A,
        S_GET_B,
        S_EXEC,
        S_OUT
    } state_t;

    state_t     r_state;
    logic [7:0] r_a;
    logic [7:0] r_b;
    logic [2:0] r_op;
    logic       r_chain;
    logic [7:0] r_out_data;
    logic       r_out_valid;
    logic [1:0] r_flags;

    logic       w_accept;
    logic [8:0] w_sum;
    logic [7:0] w_result;
    logic       w_carry;

    assign in_ready  = (r_state == S_IDLE) || (r_state == S_GET_A) || (r_state == S_GET_B);
    assign busy      = (r_state != S_IDLE);
    assign w_accept  = in_valid && in_ready;
    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign flags     = r_flags;

    // Carry is the adder's ninth bit for ADD and the borrow (A > B) for B-A.
    always_comb begin
        w_sum    = {1'b0, r_a} + {1'b0, r_b};
        w_result = 8'h00;
        w_carry  = 1'b0;
        case (r_op)
            3'b000: w_result = r_a | r_b;
            3'b001: w_result = ~(r_a & r_b);
            3'b010: w_result = ~(r_a | r_b);
            3'b011: w_result = r_a & r_b;
            3'b100: begin
                w_result = w_sum[7:0];
                w_carry  = w_sum[8];
            end
            3'b101: begin
                w_result = r_b - r_a;
                w_carry  = (r_a > r_b);
            end
            default: w_result = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_a         <= 8'h00;
            r_b         <= 8'h00;
            r_op        <= 3'b000;
            r_chain     <= 1'b0;
            r_out_data  <= 8'h00;
            r_out_valid <= 1'b0;
            r_flags     <= 2'b00;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        case (in_data[7:6])
                            2'b00: r_state <= S_GET_A;
                            2'b01: r_state <= S_GET_B;
                            2'b10: begin
                                r_op    <= in_data[2:0];
                                r_chain <= in_data[3];
                                r_state <= S_EXEC;
                            end
                            default: r_state <= S_IDLE;
                        endcase
                    end
                end
                S_GET_A: begin
                    if (w_accept) begin
                        r_a     <= in_data;
                        r_state <= S_IDLE;
                    end
                end
                S_GET_B: begin
                    if (w_accept) begin
                        r_b     <= in_data;
                        r_state <= S_IDLE;
                    end
                end
                S_EXEC: begin
                    // Chain writeback lands on the same edge the ALU reads the old A.
                    r_out_data  <= w_result;
                    r_flags     <= {w_carry, (w_result == 8'h00)};
                    r_out_valid <= 1'b1;
                    if (r_chain) begin
                        r_a <= w_result;
                    end
                    r_state <= S_OUT;
                end
                S_OUT: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tt_rebot449_alu_sequencer.sv
// Directed bench for the ALU sequencer: hand-computed results checked with
// immediate assertions after each step.
module tb_tt_rebot449_alu_sequencer;

    logic       clk;
    logic       rst_n;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic [1:0] flags;
    logic       busy;

    int total;
    int bad;

    tt_rebot449_alu_sequencer dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .flags    (flags),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Present one byte and hold it until it is accepted on a clock edge.
    task automatic applyStimulus(input logic [7:0] b);
        int waitCycles;
        in_data    = b;
        in_valid   = 1'b1;
        waitCycles = 0;
        while (in_ready !== 1'b1 && waitCycles < 20) begin
            @(posedge clk);
            #1;
            waitCycles++;
        end
        if (in_ready !== 1'b1) begin
            checkOutput("in_ready_timeout", {15'd0, in_ready}, 16'd1);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic loadOperands(input logic [7:0] a, input logic [7:0] b);
        applyStimulus(8'h00);
        applyStimulus(a);
        applyStimulus(8'h40);
        applyStimulus(b);
    endtask

    // Issue EXEC, check the EXEC cycle, the OUT cycle, and the drain back to IDLE.
    task automatic runExec(input string tag, input logic [7:0] cmd,
                           input logic [7:0] expData, input logic [1:0] expFlags);
        applyStimulus(cmd);
        checkOutput({tag, "_exec_valid"}, {15'd0, out_valid}, 16'd0);
        checkOutput({tag, "_exec_ready"}, {15'd0, in_ready}, 16'd0);
        @(posedge clk);
        #1;
        checkOutput({tag, "_valid"}, {15'd0, out_valid}, 16'd1);
        checkOutput({tag, "_data"}, {8'd0, out_data}, {8'd0, expData});
        checkOutput({tag, "_flags"}, {14'd0, flags}, {14'd0, expFlags});
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checkOutput({tag, "_drain_valid"}, {15'd0, out_valid}, 16'd0);
        checkOutput({tag, "_drain_busy"}, {15'd0, busy}, 16'd0);
        checkOutput({tag, "_hold_data"}, {8'd0, out_data}, {8'd0, expData});
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_busy"}, {15'd0, busy}, 16'd0);
        checkOutput({tag, "_in_ready"}, {15'd0, in_ready}, 16'd1);
        checkOutput({tag, "_out_valid"}, {15'd0, out_valid}, 16'd0);
        checkOutput({tag, "_out_data"}, {8'd0, out_data}, 16'd0);
        checkOutput({tag, "_flags"}, {14'd0, flags}, 16'd0);
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst_n     = 1'b0;
        in_data   = 8'h00;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkResetState("reset");
        rst_n = 1'b1;

        // Load A twice (last write wins), then ADD with carry-out and zero result.
        applyStimulus(8'h00);
        applyStimulus(8'h00);
        applyStimulus(8'h00);
        applyStimulus(8'hFF);
        applyStimulus(8'h40);
        applyStimulus(8'h01);
        runExec("add_wrap", 8'h84, 8'h00, 2'b11);

        loadOperands(8'h07, 8'h05);
        runExec("sub_borrow", 8'h85, 8'hFE, 2'b10);
        loadOperands(8'h05, 8'h07);
        runExec("sub_plain", 8'h85, 8'h02, 2'b00);

        loadOperands(8'h0F, 8'hF0);
        runExec("op000", 8'h80, 8'hFF, 2'b00);
        runExec("op001", 8'h81, 8'hFF, 2'b00);
        runExec("op010", 8'h82, 8'h00, 2'b01);
        runExec("op011", 8'h83, 8'h00, 2'b01);
        runExec("op100", 8'h84, 8'hFF, 2'b00);
        runExec("op101", 8'h85, 8'hE1, 2'b00);
        runExec("op110", 8'h86, 8'h00, 2'b01);
        runExec("op111", 8'h87, 8'h00, 2'b01);

        // NOP and a stray out_ready in IDLE must leave everything untouched.
        applyStimulus(8'hC0);
        checkOutput("nop_busy", {15'd0, busy}, 16'd0);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checkOutput("stray_ready_valid", {15'd0, out_valid}, 16'd0);
        checkOutput("stray_ready_data", {8'd0, out_data}, 16'd0);

        loadOperands(8'h01, 8'h01);
        runExec("chain1", 8'h8C, 8'h02, 2'b00);
        runExec("chain2", 8'h8C, 8'h03, 2'b00);
        runExec("chain3", 8'h8C, 8'h04, 2'b00);
        runExec("chain_a", 8'h80, 8'h05, 2'b00);

        // Backpressure: output held, offered LOAD_A byte must not be consumed.
        applyStimulus(8'h85);
        @(posedge clk);
        #1;
        in_data  = 8'h00;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            checkOutput("hold_valid", {15'd0, out_valid}, 16'd1);
            checkOutput("hold_data", {8'd0, out_data}, 16'h00FD);
            checkOutput("hold_ready", {15'd0, in_ready}, 16'd0);
        end
        checkOutput("hold_flags", {14'd0, flags}, 16'd2);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checkOutput("release_valid", {15'd0, out_valid}, 16'd0);
        checkOutput("release_busy", {15'd0, busy}, 16'd0);
        checkOutput("release_data", {8'd0, out_data}, 16'h00FD);
        runExec("hold_a_intact", 8'h80, 8'h05, 2'b00);

        // Reset in the middle of a LOAD_A.
        applyStimulus(8'h00);
        checkOutput("get_a_busy", {15'd0, busy}, 16'd1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        checkResetState("rst_get_a");
        runExec("rst_operands", 8'h80, 8'h00, 2'b01);

        // Reset while a result waits in OUT.
        loadOperands(8'h12, 8'h21);
        applyStimulus(8'h80);
        @(posedge clk);
        #1;
        checkOutput("pre_rst_valid", {15'd0, out_valid}, 16'd1);
        checkOutput("pre_rst_data", {8'd0, out_data}, 16'h0033);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        checkResetState("rst_out");

        loadOperands(8'h12, 8'h21);
        runExec("post_rst", 8'h80, 8'h33, 2'b00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
